// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
//   Sequences one data-memory access per load/store instruction through a
//   three-state FSM (IDLE -> REQ -> DONE). The address, store data, access
//   type and register-write enable are latched when the request is accepted.
//   They stay frozen until the memory acknowledges the access. The PC is held
//   through the access and released in DONE.
//
// Optional feature: define MEM_TIMEOUT_EN to abort a REQ that has not been
//   acknowledged within TIMEOUT_CYCLES cycles. The abort raises err and
//   returns to IDLE. Without the macro, REQ waits for mem_ack indefinitely.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   MEM_RS, MEM_WS        read / write request from decode (sampled in IDLE)
//   CNTRL_RS              register write enable from decode (latched)
//   addr_in, wdata_in     effective address and store data (latched)
//   mem_req, mem_we       memory request and direction (1 = write)
//   mem_addr, mem_wdata   latched address / store data
//   mem_ack, mem_rdata    memory completion pulse and read data
//   rd_data, rd_valid     captured load data and its one-cycle valid
//   reg_we                one-cycle register write enable in DONE
//   stall                 PC hold
//   err                   one-cycle error pulse (illegal request / timeout)
module mem_access_sequencer #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_RS,
    input  logic                  MEM_WS,
    input  logic                  CNTRL_RS,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  reg_we,
    output logic                  stall,
    output logic                  err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_sequencer: TIMEOUT_CYCLES must be in 2..255");
    end

    logic [1:0] state;
    logic       we_q;
    logic       cntrl_q;
    logic       one_req;
    logic       both_req;
    logic       timeout;

    assign one_req  = MEM_RS ^ MEM_WS;
    assign both_req = MEM_RS & MEM_WS;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt;
    // cnt holds the number of REQ cycles already completed. The current cycle
    // is the last one allowed when cnt+1 reaches the limit.
    assign timeout = (cnt + 8'd1) == TO_LIMIT;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            cntrl_q   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_data   <= '0;
            err       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt       <= 8'd0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (one_req) begin
                        we_q      <= MEM_WS;
                        cntrl_q   <= CNTRL_RS;
                        mem_addr  <= addr_in;
                        mem_wdata <= wdata_in;
                        state     <= REQ;
`ifdef MEM_TIMEOUT_EN
                        cnt       <= 8'd0;
`endif
                    end else if (both_req) begin
                        err <= 1'b1;
                    end
                end
                REQ: begin
                    // ack is checked first so an ack in the final allowed
                    // cycle still completes the access
                    if (mem_ack) begin
                        if (!we_q) rd_data <= mem_rdata;
                        state <= DONE;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else begin
                        cnt <= cnt + 8'd1;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req  = (state == REQ);
    assign mem_we   = we_q;
    assign rd_valid = (state == DONE) && !we_q;
    assign reg_we   = (state == DONE) && cntrl_q;
    assign stall    = (state == REQ) || ((state == IDLE) && one_req);

endmodule

// File: tb/tb_mem_access_sequencer.sv
module tb_mem_access_sequencer;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst, MEM_RS, MEM_WS, CNTRL_RS, mem_ack;
    logic [31:0] addr_in, wdata_in, mem_rdata;
    logic        mem_req, mem_we, rd_valid, reg_we, stall, err;
    logic [31:0] mem_addr, mem_wdata, rd_data;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    mem_access_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .MEM_RS(MEM_RS), .MEM_WS(MEM_WS), .CNTRL_RS(CNTRL_RS),
        .addr_in(addr_in), .wdata_in(wdata_in), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .reg_we(reg_we), .stall(stall), .err(err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_quiet();
        MEM_RS = 1'b0; MEM_WS = 1'b0; CNTRL_RS = 1'b0; mem_ack = 1'b0;
        addr_in = $urandom; wdata_in = $urandom; mem_rdata = $urandom;
    endtask

    // One instruction: request presented in IDLE; the memory acks in REQ
    // cycle ackd (1-based); rst pulses in REQ cycle rstc (0 = never).
    task automatic access(input bit rs, input bit ws, input bit cn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int ackd, input int rstc, input logic [31:0] rdv);
        logic [31:0] ack_data;
        @(negedge clk);
        rst = 1'b0; MEM_RS = rs; MEM_WS = ws; CNTRL_RS = cn;
        addr_in = addr; wdata_in = wd; mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        chk("idle_stall", stall, rs ^ ws);
        chk("idle_req", mem_req, 0);
        chk("idle_err", err, 0);
        chk("idle_rdvalid", rd_valid, 0);
        chk("idle_regwe", reg_we, 0);
        chk("idle_rddata", rd_data, exp_rd);
        if (!(rs ^ ws)) begin
            if (rs & ws) begin
                @(negedge clk); drive_quiet(); #1;
                chk("illegal_err", err, 1);
                chk("illegal_req", mem_req, 0);
                chk("illegal_stall", stall, 0);
                @(negedge clk); #1;
                chk("illegal_err_end", err, 0);
                chk("illegal_req_end", mem_req, 0);
            end
            return;
        end
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            MEM_RS = 1'($urandom); MEM_WS = 1'($urandom); CNTRL_RS = 1'($urandom);
            addr_in = $urandom; wdata_in = $urandom;
            mem_rdata = (c == ackd) ? rdv : $urandom;
            mem_ack = (c == ackd);
            rst = (c == rstc);
            #1;
            chk("req_req", mem_req, 1);
            chk("req_we", mem_we, ws);
            chk("req_addr", mem_addr, addr);
            chk("req_wdata", mem_wdata, wd);
            chk("req_stall", stall, 1);
            chk("req_err", err, 0);
            chk("req_rdvalid", rd_valid, 0);
            chk("req_regwe", reg_we, 0);
            ack_data = mem_rdata;
            if (rst) begin
                @(negedge clk); rst = 1'b0; drive_quiet(); #1;
                exp_rd = '0;
                chk("abort_req", mem_req, 0);
                chk("abort_err", err, 0);
                chk("abort_rdvalid", rd_valid, 0);
                chk("abort_regwe", reg_we, 0);
                chk("abort_addr", mem_addr, 0);
                chk("abort_wdata", mem_wdata, 0);
                chk("abort_we", mem_we, 0);
                chk("abort_rddata", rd_data, exp_rd);
                chk("abort_stall", stall, 0);
                return;
            end
            if (mem_ack) begin
                if (!ws) exp_rd = ack_data;
                // DONE: inputs (including a stray ack) must be ignored
                @(negedge clk);
                MEM_RS = 1'($urandom); MEM_WS = 1'($urandom);
                mem_ack = 1'($urandom); mem_rdata = $urandom;
                #1;
                chk("done_rdvalid", rd_valid, !ws);
                chk("done_regwe", reg_we, cn);
                chk("done_stall", stall, 0);
                chk("done_req", mem_req, 0);
                chk("done_err", err, 0);
                chk("done_rddata", rd_data, exp_rd);
                return;
            end
`ifdef MEM_TIMEOUT_EN
            if (c == T) begin
                @(negedge clk); drive_quiet(); mem_ack = 1'b1; #1;
                chk("to_err", err, 1);
                chk("to_req", mem_req, 0);
                chk("to_regwe", reg_we, 0);
                chk("to_rdvalid", rd_valid, 0);
                chk("to_rddata", rd_data, exp_rd);
                chk("to_stall", stall, 0);
                @(negedge clk); mem_ack = 1'b0; #1;
                chk("late_err", err, 0);
                chk("late_req", mem_req, 0);
                chk("late_rdvalid", rd_valid, 0);
                chk("late_regwe", reg_we, 0);
                return;
            end
`endif
        end
        chk("req_wait_bound", 64, ackd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ackd, rstc, kind;
        bit rs;
        rst = 1'b1; drive_quiet(); exp_rd = '0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_rdvalid", rd_valid, 0);
        chk("rst_regwe", reg_we, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rddata", rd_data, 0);
        chk("rst_stall0", stall, 0);
        MEM_RS = 1'b1; #1;
        chk("rst_stall1", stall, 1);

        // read, ack in 2nd REQ cycle
        access(1, 0, 1, 32'h40, 32'h0, 2, 0, 32'hDEADBEEF);
        chk("read_rddata", rd_data, 32'hDEADBEEF);
        // write, immediate ack
        access(0, 1, 0, 32'h10, 32'h12345678, 1, 0, 32'h0);
        // illegal double request
        access(1, 1, 1, 32'h20, 32'h0, 1, 0, 32'h0);
`ifdef MEM_TIMEOUT_EN
        access(1, 0, 1, 32'h80, 32'h0, 99, 0, 32'h0);
        // ack on the last allowed cycle wins over the timeout
        access(1, 0, 1, 32'h84, 32'h0, T, 0, 32'hCAFEF00D);
`endif
        // reset in 2nd REQ cycle, then a normal read
        access(1, 0, 1, 32'h44, 32'h0, 5, 2, 32'h0);
        access(1, 0, 1, 32'h48, 32'h0, 1, 0, 32'h0BADF00D);
        // back-to-back read then write
        access(1, 0, 1, 32'h50, 32'h0, 1, 0, 32'h11112222);
        access(0, 1, 1, 32'h54, 32'h33334444, 1, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            rs   = 1'($urandom);
            ackd = $urandom_range(1, 6);
            rstc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, ackd) : 0;
            if (kind == 0)      access(1, 1, 1'($urandom), $urandom, $urandom, ackd, 0, $urandom);
            else if (kind == 1) access(0, 0, 1'($urandom), $urandom, $urandom, ackd, 0, $urandom);
            else                access(rs, !rs, 1'($urandom), $urandom, $urandom, ackd, rstc, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, data-memory address width; DATA_WIDTH, 32, data word width; TIMEOUT_CYCLES, 16, max cycles to wait for mem_ack (range 2..255).
REQ-002 The block SHALL use one clock, and reset SHALL be synchronous and active-high; the ports are:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
MEM_RS  input  1  memory read request from control decode
MEM_WS  input  1  memory write request from control decode
CNTRL_RS  input  1  register write enable from control decode
addr_in  input  ADDR_WIDTH  effective address (ALU result)
wdata_in  input  DATA_WIDTH  store data
mem_req  output  1  data-memory request
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_WIDTH  latched address
mem_wdata  output  DATA_WIDTH  latched store data
mem_ack  input  1  memory completion, single-cycle pulse
mem_rdata  input  DATA_WIDTH  read data, valid with mem_ack
rd_data  output  DATA_WIDTH  captured load data
rd_valid  output  1  one-cycle pulse, load data ready for write-back
reg_we  output  1  one-cycle register write enable for the completed access
stall  output  1  PC hold; 1 = PC SHALL NOT update
err  output  1  one-cycle error pulse

Function
REQ-003 The FSM SHALL have states IDLE, REQ, and DONE.
REQ-004 In IDLE, exactly one of MEM_RS or MEM_WS high at a clock edge SHALL latch addr_in, wdata_in, CNTRL_RS, and the access type, and SHALL move to REQ.
REQ-005 In IDLE, MEM_RS and MEM_WS both high SHALL start no access, SHALL pulse err for one cycle, and SHALL remain in IDLE.
REQ-006 In REQ, mem_req SHALL be 1, and mem_we/mem_addr/mem_wdata SHALL hold the latched values stable until mem_ack.
REQ-007 mem_ack in REQ SHALL capture mem_rdata into rd_data (reads only) and SHALL move to DONE; mem_ack in any other state SHALL be ignored.
REQ-008 In DONE (exactly one cycle): reg_we SHALL equal the latched CNTRL_RS, and rd_valid SHALL be 1 for reads and 0 for writes; the FSM SHALL then return to IDLE.
REQ-009 stall SHALL equal (state==REQ) OR (state==IDLE AND exactly one of MEM_RS/MEM_WS high), combinationally; stall SHALL be 0 in DONE so the PC advances at the end of DONE.
REQ-010 Request inputs SHALL be sampled only in IDLE; inputs during REQ or DONE SHALL be ignored.
REQ-011 Minimum access latency SHALL be 3 cycles from request to rd_valid (IDLE->REQ, ack in first REQ cycle, DONE).
REQ-012 rd_data SHALL hold its value until the next completed read.

Reset
REQ-013 rst high at a clock edge SHALL force IDLE and SHALL clear the timeout counter and all latched registers to 0, from any state including mid-REQ.
REQ-014 After reset: mem_req, mem_we, rd_valid, reg_we, err = 0; mem_addr, mem_wdata, rd_data = 0; stall reflects inputs per REQ-009.
REQ-015 An aborted access SHALL produce no reg_we, rd_valid, or err pulse.

Configuration
REQ-016 Macro MEM_TIMEOUT_EN defined: an 8-bit counter SHALL count REQ cycles; if the count reaches TIMEOUT_CYCLES without mem_ack, the FSM SHALL return to IDLE with err=1 for one cycle, mem_req=0, reg_we=0, rd_valid=0, and rd_data unchanged.
REQ-017 Macro MEM_TIMEOUT_EN undefined: no counter SHALL exist, REQ SHALL wait indefinitely, and err SHALL come only from REQ-005.
REQ-018 A mem_ack arriving in the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally (ack wins).

Verification
REQ-019 Read: MEM_RS=1, CNTRL_RS=1, addr_in=0x40; ack after 2 REQ cycles with rdata=0xDEADBEEF -> mem_addr=0x40, mem_we=0, stall high 3 cycles, then rd_valid=1, reg_we=1, rd_data=0xDEADBEEF.
REQ-020 Write: MEM_WS=1, CNTRL_RS=0, addr_in=0x10, wdata_in=0x12345678, immediate ack -> mem_we=1, mem_wdata=0x12345678, DONE with rd_valid=0, reg_we=0.
REQ-021 Illegal: MEM_RS=MEM_WS=1 -> err pulse 1 cycle, mem_req never asserted, stall=0.
REQ-022 Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): read, no ack -> mem_req high exactly 4 cycles, then err=1, reg_we=0, IDLE; a late ack is ignored.
REQ-023 Reset mid-operation: rst in the 2nd REQ cycle -> next cycle mem_req=0, IDLE, no reg_we/rd_valid/err; a subsequent read completes normally.
REQ-024 Back-to-back: read then write presented on consecutive instructions -> the second request is accepted only in IDLE after DONE, with no overlap of mem_req.
